// File: rtl/spram_pkg.sv
// Shared definitions for the 32K x 32 single-port RAM and its 16K x 16
// macro wrappers.
//
// Contents:
//   ASZ / DSZ           word address width and data width of the full RAM
//   MACRO_ASZ/MACRO_DSZ address and data width of one 16K x 16 macro
//   MACRO_NIBBLES       number of 4-bit write-mask lanes per macro
//   word_addr_t, data_word_t, macro_addr_t, macro_data_t
//   byte_to_nibble()    expands two byte enables into four nibble enables
package spram_pkg;

  localparam int ASZ           = 15;
  localparam int DSZ           = 32;
  localparam int MACRO_ASZ     = 14;
  localparam int MACRO_DSZ     = 16;
  localparam int MACRO_WORDS   = 1 << MACRO_ASZ;
  localparam int MACRO_NIBBLES = MACRO_DSZ / 4;

  typedef logic [ASZ-1:0]       word_addr_t;
  typedef logic [DSZ-1:0]       data_word_t;
  typedef logic [MACRO_ASZ-1:0] macro_addr_t;
  typedef logic [MACRO_DSZ-1:0] macro_data_t;

  // Each byte of a 16-bit macro half is covered by two nibble lanes, so a
  // byte enable simply drives both of its nibbles.
  function automatic logic [MACRO_NIBBLES-1:0] byte_to_nibble(input logic [1:0] byte_en);
    return {byte_en[1], byte_en[1], byte_en[0], byte_en[0]};
  endfunction

endpackage

// File: rtl/spram16_16k.sv
// 16K x 16 single-port RAM macro wrapper with nibble write mask.
//
// Behavioural model of the hard macro: one access per clock, writes are
// masked per nibble, reads are registered (data visible after the edge that
// sampled the address).
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset, clears the read register only
//   rd_en  in   perform a read this cycle (q updates)
//   wr_en  in   perform a write this cycle (q holds)
//   nmsk   in   [3:0] nibble write enables, bit n covers d[4n+3:4n]
//   a      in   [13:0] macro word address
//   d      in   [15:0] write data
//   q      out  [15:0] registered read data
module spram16_16k
  import spram_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic                     wr_en,
  input  logic [MACRO_NIBBLES-1:0] nmsk,
  input  macro_addr_t              a,
  input  macro_data_t              d,
  output macro_data_t              q
);

  macro_data_t mem [MACRO_WORDS];
  macro_data_t q_d;
  macro_data_t q_q;

  // Nibble-granular write; untouched nibbles keep their contents. Reset does
  // not clear the array, callers gate wr_en when writes must be suppressed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int n = 0; n < MACRO_NIBBLES; n++) begin
        if (nmsk[n]) begin
          mem[a][n*4 +: 4] <= d[n*4 +: 4];
        end
      end
    end
  end

  // The read register only moves on a read, so it holds across write cycles.
  always_comb begin
    q_d = q_q;
    if (rst) begin
      q_d = '0;
    end else if (rd_en) begin
      q_d = mem[a];
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/spram32_32k.sv
// 32K x 32 single-port synchronous RAM with per-byte write enables, built
// from four 16K x 16 macros: two address banks, each split into a low half
// (bits 15:0) and a high half (bits 31:16).
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset: clears vo and the registered
//              bank select, suppresses any write in the same cycle
//   we    in   1 = write, 0 = read
//   bmsk  in   [3:0] byte write mask, bit n enables vi[8n+7:8n]
//   a     in   [14:0] word address, a[14] selects the bank
//   vi    in   [31:0] write data
//   vo    out  [31:0] registered read data, one-cycle latency, holds on writes
//
// Only the default ASZ/DSZ values are supported.
module spram32_32k #(
  parameter int ASZ = spram_pkg::ASZ,
  parameter int DSZ = spram_pkg::DSZ
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [3:0]     bmsk,
  input  logic [ASZ-1:0] a,
  input  logic [DSZ-1:0] vi,
  output logic [DSZ-1:0] vo
);

  import spram_pkg::*;

  logic        bank_sel;
  macro_addr_t in_bank_addr;
  logic        rd_en;
  logic [1:0]  bank_wr_en;
  logic [MACRO_NIBBLES-1:0] lo_nmsk;
  logic [MACRO_NIBBLES-1:0] hi_nmsk;

  macro_data_t lo_q [2];
  macro_data_t hi_q [2];

  logic bank_d;
  logic bank_q;

  assign bank_sel     = a[ASZ-1];
  assign in_bank_addr = a[MACRO_ASZ-1:0];

  // Reads go to both banks so the output mux only needs the registered bank
  // select; writes reach only the addressed bank and are dropped under reset.
  always_comb begin
    rd_en         = ~rst & ~we;
    bank_wr_en    = 2'b00;
    bank_wr_en[0] = ~rst & we & ~bank_sel;
    bank_wr_en[1] = ~rst & we &  bank_sel;
    lo_nmsk       = byte_to_nibble(bmsk[1:0]);
    hi_nmsk       = byte_to_nibble(bmsk[3:2]);
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    spram16_16k u_lo (
      .clk   (clk),
      .rst   (rst),
      .rd_en (rd_en),
      .wr_en (bank_wr_en[b]),
      .nmsk  (lo_nmsk),
      .a     (in_bank_addr),
      .d     (vi[MACRO_DSZ-1:0]),
      .q     (lo_q[b])
    );

    spram16_16k u_hi (
      .clk   (clk),
      .rst   (rst),
      .rd_en (rd_en),
      .wr_en (bank_wr_en[b]),
      .nmsk  (hi_nmsk),
      .a     (in_bank_addr),
      .d     (vi[DSZ-1:MACRO_DSZ]),
      .q     (hi_q[b])
    );
  end

  // Bank select is captured on the same edge as the macro read data, and
  // like it only advances on reads, so vo holds through write cycles.
  always_comb begin
    bank_d = bank_q;
    if (rst) begin
      bank_d = 1'b0;
    end else if (rd_en) begin
      bank_d = bank_sel;
    end
  end

  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  assign vo = bank_q ? {hi_q[1], lo_q[1]} : {hi_q[0], lo_q[0]};

endmodule

// File: tb/tb_spram32_32k.sv
// Self-checking bench for spram32_32k: directed scenarios followed by a
// randomized mix of reads, masked writes and resets, all compared against a
// word/byte-level memory model.
module tb_spram32_32k;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [3:0]  bmsk;
  logic [14:0] a;
  logic [31:0] vi;
  logic [31:0] vo;

  int totalCount = 0;
  int badCount   = 0;

  // Reference model: word contents plus which bytes have ever been written,
  // so never-written (undefined) bytes are excluded from comparisons.
  logic [31:0] modelMem   [int];
  logic [3:0]  modelKnown [int];
  logic [31:0] expVo;
  logic [3:0]  expKnown;

  logic [14:0] addrPool [8];

  spram32_32k dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .bmsk (bmsk),
    .a    (a),
    .vi   (vi),
    .vo   (vo)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] byteMask(input logic [3:0] k);
    logic [31:0] m;
    for (int n = 0; n < 4; n++) m[n*8 +: 8] = {8{k[n]}};
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents one operation for one clock, advances the model and compares vo
  // shortly after the edge.
  task automatic applyStimulus(input logic r, input logic w, input logic [3:0] m,
                               input logic [14:0] addr, input logic [31:0] data);
    int key;
    rst  = r;
    we   = w;
    bmsk = m;
    a    = addr;
    vi   = data;
    @(posedge clk);
    #1;
    key = int'(addr);
    if (r) begin
      expVo    = 32'h0;
      expKnown = 4'hF;
    end else if (w) begin
      if (!modelMem.exists(key)) begin
        modelMem[key]   = 32'h0;
        modelKnown[key] = 4'h0;
      end
      for (int n = 0; n < 4; n++) begin
        if (m[n]) begin
          modelMem[key][n*8 +: 8] = data[n*8 +: 8];
          modelKnown[key][n]      = 1'b1;
        end
      end
    end else begin
      if (modelMem.exists(key)) begin
        expVo    = modelMem[key];
        expKnown = modelKnown[key];
      end else begin
        expVo    = 32'h0;
        expKnown = 4'h0;
      end
    end
    if (expKnown != 4'h0)
      checkOutput("vo_model", vo & byteMask(expKnown), expVo & byteMask(expKnown));
  endtask

  initial begin
    logic [31:0] pat;
    logic [14:0] ra;
    int          sel;

    rst = 1'b1; we = 1'b0; bmsk = 4'h0; a = '0; vi = '0;
    expVo = '0; expKnown = 4'h0;

    applyStimulus(1, 0, 4'h0, 15'h0, 32'h0);
    applyStimulus(1, 1, 4'hF, 15'h0, 32'h0);
    checkOutput("reset_vo", vo, 32'h0);
    applyStimulus(0, 1, 4'hF, 15'h3, 32'h55AA55AA);
    checkOutput("vo_zero_until_read", vo, 32'h0);

    // Walking-bit pattern at both ends of the address space.
    for (int i = 0; i < 15; i++) begin
      pat = ~(32'(i));
      pat = pat << i;
      applyStimulus(0, 1, 4'hF, 15'(1 << i), pat);
      applyStimulus(0, 1, 4'hF, 15'(15'h7FFF - i), pat);
    end
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 0, 4'h0, 15'(1 << i), 32'h0);
      applyStimulus(0, 0, 4'h0, 15'(15'h7FFF - i), 32'h0);
    end
    applyStimulus(0, 0, 4'h0, 15'h0001, 32'h0);
    checkOutput("pat_0001", vo, 32'hFFFFFFFF);
    applyStimulus(0, 0, 4'hF, 15'h0002, 32'h0);
    checkOutput("pat_0002", vo, 32'hFFFFFFFC);
    applyStimulus(0, 0, 4'h0, 15'h4000, 32'h0);
    checkOutput("pat_4000", vo, 32'hFFFC4000);
    applyStimulus(0, 0, 4'h0, 15'h7FFE, 32'h0);
    checkOutput("pat_7ffe", vo, 32'hFFFFFFFC);

    // Byte mask merge.
    applyStimulus(0, 1, 4'b1111, 15'h0100, 32'h11223344);
    applyStimulus(0, 1, 4'b0101, 15'h0100, 32'hAABBCCDD);
    applyStimulus(0, 1, 4'b0000, 15'h0100, 32'h99999999);
    applyStimulus(0, 0, 4'h0,    15'h0100, 32'h0);
    checkOutput("byte_mask", vo, 32'h11BB33DD);

    // Bank isolation, back-to-back writes to both banks.
    applyStimulus(0, 1, 4'hF, 15'h0005, 32'hDEADBEEF);
    applyStimulus(0, 1, 4'hF, 15'h4005, 32'h12345678);
    applyStimulus(0, 0, 4'h0, 15'h0005, 32'h0);
    checkOutput("bank0_iso", vo, 32'hDEADBEEF);
    applyStimulus(0, 0, 4'h0, 15'h4005, 32'h0);
    checkOutput("bank1_iso", vo, 32'h12345678);

    // vo holds through a write cycle; read right after write sees new data.
    applyStimulus(0, 0, 4'h0, 15'h0001, 32'h0);
    checkOutput("pre_write_read", vo, 32'hFFFFFFFF);
    applyStimulus(0, 1, 4'hF, 15'h0002, 32'h0);
    checkOutput("write_cycle_hold", vo, 32'hFFFFFFFF);
    applyStimulus(0, 0, 4'h0, 15'h0002, 32'h0);
    checkOutput("read_after_write", vo, 32'h00000000);

    // Reset suppresses a concurrent write and leaves memory intact.
    applyStimulus(0, 0, 4'h0, 15'h4005, 32'h0);
    applyStimulus(1, 1, 4'hF, 15'h0001, 32'h0);
    checkOutput("reset_mid_run", vo, 32'h0);
    applyStimulus(0, 0, 4'h0, 15'h0001, 32'h0);
    checkOutput("reset_no_write", vo, 32'hFFFFFFFF);

    // Randomized mix over a small pool so reads mostly hit written words.
    addrPool[0] = 15'h0000; addrPool[1] = 15'h3FFF; addrPool[2] = 15'h4000;
    addrPool[3] = 15'h7FFF; addrPool[4] = 15'h0100; addrPool[5] = 15'h4100;
    addrPool[6] = 15'h2A55; addrPool[7] = 15'h6A55;
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 1, 4'hF, addrPool[i], $urandom);
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      ra  = (sel == 9) ? 15'($urandom_range(0, 32767)) : addrPool[sel % 8];
      if ($urandom_range(0, 49) == 0)
        applyStimulus(1, $urandom_range(0, 1), 4'($urandom), ra, $urandom);
      else if ($urandom_range(0, 1) == 0)
        applyStimulus(0, 1, 4'($urandom), ra, $urandom);
      else
        applyStimulus(0, 0, 4'($urandom), ra, $urandom);
    end

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
